// File: rtl/wb_pipe_pkg.sv
// Shared constants, stage record and age-width helper for the writeback-tag delay pipeline.
package wb_pipe_pkg;

  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DEPTH  = 2;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic                      wr;
  } stage_t;

  // Width of one hazard-age field; never narrower than one bit even at DEPTH=1.
  function automatic int age_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/wb_pipe_stage.sv
// One {addr, wr} delay stage: synchronous RST, flush clears wr only, stall holds, else load.
module wb_pipe_stage
  import wb_pipe_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              flush,
  input  logic              stall,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_wr,
  output logic [ADDR_W-1:0] addr_q,
  output logic              wr_q
);

  logic [ADDR_W-1:0] addr_d;
  logic              wr_d;

  // Next-state: flush outranks stall, and the address survives a flush untouched.
  always_comb begin
    addr_d = addr_q;
    wr_d   = wr_q;
    if (flush) begin
      wr_d = 1'b0;
    end else if (!stall) begin
      addr_d = load_addr;
      wr_d   = load_wr;
    end else begin
      wr_d = wr_q;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wr_q   <= wr_d;
    end
  end

endmodule

// File: rtl/wb_pipe.sv
// DEPTH-stage writeback-tag delay line with stall/flush, occupancy count and optional
// in-flight hazard lookup (built only when WB_PIPE_FWD_EN is defined).
module wb_pipe
  import wb_pipe_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int ADDR_W = DEFAULT_ADDR_W,
  parameter  int NSRC   = 2,
  localparam int AGE_W  = age_width(DEPTH),
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      dst,
  input  logic                   write_alu,
  output logic [ADDR_W-1:0]      dst_delay,
  output logic                   write_alu_delay,
  input  logic [NSRC*ADDR_W-1:0] src,
  output logic [NSRC-1:0]        hazard,
  output logic [NSRC*AGE_W-1:0]  hazard_age,
  output logic [OCC_W-1:0]       occupancy
);

  logic [ADDR_W-1:0] addr_vec [DEPTH];
  logic [DEPTH-1:0]  w_vec;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [ADDR_W-1:0] in_addr_s;
    logic              in_wr_s;

    if (k == 0) begin : g_head
      assign in_addr_s = dst;
      assign in_wr_s   = write_alu;
    end else begin : g_body
      assign in_addr_s = addr_vec[k-1];
      assign in_wr_s   = w_vec[k-1];
    end

    wb_pipe_stage #(.ADDR_W(ADDR_W)) u_stage (
      .clk       (clk),
      .RST       (RST),
      .flush     (flush),
      .stall     (stall),
      .load_addr (in_addr_s),
      .load_wr   (in_wr_s),
      .addr_q    (addr_vec[k]),
      .wr_q      (w_vec[k])
    );
  end

  assign dst_delay       = addr_vec[DEPTH-1];
  assign write_alu_delay = w_vec[DEPTH-1];

  // Popcount of the per-stage write flags.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(w_vec[k]);
    end
  end

`ifdef WB_PIPE_FWD_EN
  logic [DEPTH-1:0] match_s [NSRC];

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
      assign match_s[i][k] = w_vec[k] && (addr_vec[k] == src[i*ADDR_W +: ADDR_W]);
    end
  end

  // Scan oldest to youngest so the youngest matching stage is the one left standing.
  always_comb begin
    hazard     = '0;
    hazard_age = '0;
    for (int i = 0; i < NSRC; i++) begin
      hazard[i] = |match_s[i];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        hazard_age[i*AGE_W +: AGE_W] = match_s[i][k] ? AGE_W'(k)
                                                     : hazard_age[i*AGE_W +: AGE_W];
      end
    end
  end
`else
  logic unused_src_s;

  assign unused_src_s = ^src;
  assign hazard       = '0;
  assign hazard_age   = '0;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe: directed literal cases plus randomized traffic against a queue model.
module tb_wb_pipe;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 6;
  localparam int NSRC   = 2;
  localparam int AGE_W  = 1;
  localparam int OCC_W  = 2;

  logic                   clk = 1'b0;
  logic                   RST, stall, flush, write_alu;
  logic [ADDR_W-1:0]      dst;
  logic [NSRC*ADDR_W-1:0] src;
  logic [ADDR_W-1:0]      dst_delay;
  logic                   write_alu_delay;
  logic [NSRC-1:0]        hazard;
  logic [NSRC*AGE_W-1:0]  hazard_age;
  logic [OCC_W-1:0]       occupancy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  wb_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NSRC(NSRC)) dut (
    .clk             (clk),
    .RST             (RST),
    .stall           (stall),
    .flush           (flush),
    .dst             (dst),
    .write_alu       (write_alu),
    .dst_delay       (dst_delay),
    .write_alu_delay (write_alu_delay),
    .src             (src),
    .hazard          (hazard),
    .hazard_age      (hazard_age),
    .occupancy       (occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Reference model: a queue of in-flight tags, index 0 youngest.
  typedef struct {
    logic [ADDR_W-1:0] a;
    bit                w;
  } ent_t;

  ent_t pipe[$];
  bit   model_valid = 1'b0;

  always @(posedge clk) begin
    if (RST) begin
      pipe.delete();
      for (int k = 0; k < DEPTH; k++) pipe.push_back('{a: '0, w: 1'b0});
      model_valid = 1'b1;
    end else if (model_valid && flush) begin
      foreach (pipe[k]) pipe[k].w = 1'b0;
    end else if (model_valid && !stall) begin
      pipe.push_front('{a: dst, w: write_alu});
      void'(pipe.pop_back());
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      int                    cnt;
      logic [NSRC-1:0]       exp_h;
      logic [NSRC*AGE_W-1:0] exp_age;
      cnt     = 0;
      exp_h   = '0;
      exp_age = '0;
      foreach (pipe[k]) if (pipe[k].w) cnt++;
      for (int i = 0; i < NSRC; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!exp_h[i] && pipe[k].w && pipe[k].a == src[i*ADDR_W +: ADDR_W]) begin
            exp_h[i] = 1'b1;
            exp_age[i*AGE_W +: AGE_W] = AGE_W'(k);
          end
        end
      end
`ifndef WB_PIPE_FWD_EN
      exp_h   = '0;
      exp_age = '0;
`endif
      check("model_dst_delay", 32'(dst_delay), 32'(pipe[DEPTH-1].a));
      check("model_write_alu_delay", 32'(write_alu_delay), 32'(pipe[DEPTH-1].w));
      check("model_occupancy", 32'(occupancy), 32'(cnt));
      check("model_hazard", 32'(hazard), 32'(exp_h));
      check("model_hazard_age", 32'(hazard_age), 32'(exp_age));
    end
  end

  task automatic drive(input logic r, input logic st, input logic fl,
                       input logic wa, input logic [ADDR_W-1:0] d);
    RST       = r;
    stall     = st;
    flush     = fl;
    write_alu = wa;
    dst       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NSRC-1:0]       fwd_h;
    logic [NSRC*AGE_W-1:0] fwd_age;
    RST = 1'b0; stall = 1'b0; flush = 1'b0; write_alu = 1'b0;
    dst = '0; src = '0;

    // Reset with a live write request on the input
    drive(1'b1, 1'b0, 1'b0, 1'b1, 6'h15);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 6'h15);
    check("rst_dst_delay", 32'(dst_delay), 32'h0);
    check("rst_write_alu_delay", 32'(write_alu_delay), 32'h0);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_hazard", 32'(hazard), 32'h0);

    // Two-cycle latency, single-cycle pulse
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h05);
    check("lat_early", 32'(write_alu_delay), 32'h0);
    check("lat_occ", 32'(occupancy), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    check("lat_dst", 32'(dst_delay), 32'h05);
    check("lat_wr", 32'(write_alu_delay), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    check("lat_pulse_end", 32'(write_alu_delay), 32'h0);

    // Stall holds the tag; the write request offered during stall is ignored
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h07);
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 6'h3F);
      check("stall_occ", 32'(occupancy), 32'h1);
      check("stall_wr", 32'(write_alu_delay), 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    check("stall_dst", 32'(dst_delay), 32'h07);
    check("stall_wr_out", 32'(write_alu_delay), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);

    // Flush with stall and a valid input: everything dropped
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h09);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h0A);
    check("flush_occ", 32'(occupancy), 32'h0);
    check("flush_wr", 32'(write_alu_delay), 32'h0);
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
      check("flush_no_pulse", 32'(write_alu_delay), 32'h0);
    end

    // Hazard lookup: channel 0 looks for 03, channel 1 for 11
`ifdef WB_PIPE_FWD_EN
    fwd_h = 2'b01;
    fwd_age = 2'b01;
`else
    fwd_h = 2'b00;
    fwd_age = 2'b00;
`endif
    src = {6'h11, 6'h03};
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h03);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h03);
    check("haz_dup", 32'(hazard), 32'(fwd_h));
    check("haz_dup_age", 32'(hazard_age), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h05);
    check("haz_old", 32'(hazard), 32'(fwd_h));
    check("haz_old_age", 32'(hazard_age), 32'(fwd_age));

    // Reset mid-stream discards in-flight tags
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h21);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'h22);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 6'h23);
    check("rstm_occ", 32'(occupancy), 32'h0);
    check("rstm_wr", 32'(write_alu_delay), 32'h0);
    check("rstm_dst", 32'(dst_delay), 32'h0);
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
      check("rstm_no_pulse", 32'(write_alu_delay), 32'h0);
    end

    // Randomized traffic; small address range to provoke hazards and duplicates
    for (int n = 0; n < 3000; n++) begin
      src = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 8,
            1'($urandom),
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7)));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
